// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end.
//   Owns the program counter and fetches one word at a time from instruction
//   memory over a req/ready handshake. Fetched words are handed to decode
//   through an output register backed by a one-entry skid buffer. A taken
//   branch redirects fetch and kills any fetch that is still in flight.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   stall             decode cannot accept; if_* hold while high
//   branch_taken      single-cycle redirect pulse from EX
//   branch_target     redirect address (low two bits ignored)
//   imem_req          fetch request, held until imem_ready
//   imem_addr         fetch address, stable while imem_req is high
//   imem_ready        memory completes the request this cycle
//   imem_rdata        fetched instruction, valid with imem_ready
//   if_valid          if_pc/if_instr hold a valid instruction
//   if_pc, if_instr   presented instruction and its address
//   if_pc_plus4       if_pc + 4 (combinational, wraps modulo 2^32)
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc_plus4
);

    localparam int unsigned AW = 32;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        KILL  = 2'd3
    } state_t;

    state_t              state;
    logic [AW-1:0]       pc;
    logic                skid_valid;
    logic [AW-1:0]       skid_pc;
    logic [INSTR_W-1:0]  skid_instr;

    logic [AW-1:0]       pc_inc;
    logic [AW-1:0]       target_aligned;

    assign pc_inc         = pc + AW'(4);
    assign target_aligned = {branch_target[AW-1:2], 2'b00};
    assign if_pc_plus4    = if_pc + AW'(4);

    // Fetch sequencer; redirect takes priority over everything, including stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            if_valid   <= 1'b0;
            if_pc      <= '0;
            if_instr   <= '0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (branch_taken) begin
            pc         <= target_aligned;
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
            case (state)
                FETCH: begin
                    // An outstanding fetch must finish before the address may move.
                    if (imem_ready) begin
                        imem_addr <= target_aligned;
                    end else begin
                        state <= KILL;
                    end
                end
                KILL: begin
                    // Old request stays on the bus; only the pending target changes.
                end
                default: begin
                    state     <= FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= target_aligned;
                end
            endcase
        end else begin
            case (state)
                BOOT: begin
                    state     <= FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                FETCH: begin
                    if (imem_ready) begin
                        pc <= pc_inc;
                        if (!if_valid || !stall) begin
                            if_valid  <= 1'b1;
                            if_pc     <= imem_addr;
                            if_instr  <= imem_rdata;
                            imem_addr <= pc_inc;
                        end else begin
                            // Output occupied and stalled: park the word, stop fetching.
                            skid_valid <= 1'b1;
                            skid_pc    <= imem_addr;
                            skid_instr <= imem_rdata;
                            imem_req   <= 1'b0;
                            state      <= HOLD;
                        end
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall && skid_valid) begin
                        if_valid   <= 1'b1;
                        if_pc      <= skid_pc;
                        if_instr   <= skid_instr;
                        skid_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        imem_addr  <= pc;
                        state      <= FETCH;
                    end
                end
                default: begin
                    // KILL: drain the stale fetch and discard its data.
                    if (imem_ready) begin
                        imem_addr <= pc;
                        state     <= FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios and randomized traffic, checked
// every cycle against a queue-based model of the fetch front end.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST0 = 32'h0000_0000;
    localparam logic [31:0] RST1 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = '0;
    logic        rdy = 1'b0;
    logic [31:0] rdata = '0;

    logic        req,  vld;
    logic [31:0] addr, ipc, ins, p4;
    logic        req2, vld2;
    logic [31:0] addr2, ipc2, ins2, p42;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(RST0), .INSTR_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(br),
        .branch_target(tgt), .imem_req(req), .imem_addr(addr),
        .imem_ready(rdy), .imem_rdata(rdata), .if_valid(vld),
        .if_pc(ipc), .if_instr(ins), .if_pc_plus4(p4)
    );

    pc_fetch_unit #(.RESET_PC(RST1), .INSTR_W(32)) dut_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .branch_taken(1'b0),
        .branch_target(32'h0), .imem_req(req2), .imem_addr(addr2),
        .imem_ready(1'b1), .imem_rdata(rdata), .if_valid(vld2),
        .if_pc(ipc2), .if_instr(ins2), .if_pc_plus4(p42)
    );

    // Model: instructions waiting for decode (front = presented), next pc,
    // the outstanding request and whether its data is to be thrown away.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;
    ent_t        dq[$];
    logic [31:0] m_pc, m_addr;
    bit          m_req, m_kill, m_boot;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    function automatic void m_reset(logic [31:0] rpc);
        dq.delete();
        m_pc   = rpc;
        m_addr = rpc;
        m_req  = 0;
        m_kill = 0;
        m_boot = 1;
    endfunction

    // One clock edge of the model, using the inputs present at that edge.
    function automatic void m_edge();
        bit done;
        done = m_req && rdy;
        if (m_boot) begin
            m_boot = 0;
            if (br) m_pc = {tgt[31:2], 2'b00};
            m_req  = 1;
            m_addr = m_pc;
            return;
        end
        if (br) begin
            m_pc = {tgt[31:2], 2'b00};
            dq.delete();
            if (m_req && !done) m_kill = 1;
            else if (!(done && m_kill)) begin
                m_req  = 1;
                m_addr = m_pc;
                m_kill = 0;
            end
            return;
        end
        if (!stall && dq.size() > 0) void'(dq.pop_front());
        if (done) begin
            if (m_kill) begin
                m_kill = 0;
                m_addr = m_pc;
            end else begin
                dq.push_back('{pc: m_addr, ins: rdata});
                m_pc = m_pc + 32'd4;
                if (dq.size() >= 2) m_req = 0;
                else m_addr = m_pc;
            end
        end else if (!m_req && dq.size() < 2) begin
            m_req  = 1;
            m_addr = m_pc;
        end
    endfunction

    function automatic void compare();
        chk("imem_req", 32'(req), 32'(m_req));
        chk("if_valid", 32'(vld), 32'(dq.size() > 0));
        if (m_req) chk("imem_addr", addr, m_addr);
        if (dq.size() > 0) begin
            chk("if_pc", ipc, dq[0].pc);
            chk("if_instr", ins, dq[0].ins);
            chk("if_pc_plus4", p4, dq[0].pc + 32'd4);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        compare();
        rdata = $urandom;
    endtask

    initial begin
        m_reset(RST0);
        rdata = $urandom;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_valid", 32'(vld), 32'd0);
        chk("rst_addr", addr, RST0);
        chk("rst_if_pc", ipc, 32'd0);
        chk("rst_if_instr", ins, 32'd0);
        chk("rst_wrap_addr", addr2, RST1);
        rst = 1'b0;

        // Streaming with zero wait states.
        rdy = 1'b1;
        step();
        chk("boot_addr", addr, 32'h0);
        chk("boot_valid", 32'(vld), 32'd0);
        chk("wrap_addr0", addr2, 32'hFFFF_FFF8);
        step();
        chk("first_valid", 32'(vld), 32'd1);
        chk("first_pc", ipc, 32'h0);
        chk("second_addr", addr, 32'h4);
        chk("wrap_addr1", addr2, 32'hFFFF_FFFC);
        chk("wrap_pc0", ipc2, 32'hFFFF_FFF8);
        step();
        chk("pc_4", ipc, 32'h4);
        chk("addr_8", addr, 32'h8);
        chk("wrap_addr2", addr2, 32'h0);
        chk("wrap_pc1", ipc2, 32'hFFFF_FFFC);
        chk("wrap_plus4", p42, 32'h0);
        step();
        chk("pc_8", ipc, 32'h8);
        chk("addr_c", addr, 32'hC);

        // Three-cycle stall: next word goes to the skid buffer.
        stall = 1'b1;
        step();
        chk("hold_req", 32'(req), 32'd0);
        chk("hold_pc", ipc, 32'h8);
        step();
        step();
        chk("hold_pc3", ipc, 32'h8);
        stall = 1'b0;
        step();
        chk("skid_pc", ipc, 32'hC);
        chk("skid_resume_addr", addr, 32'h10);
        step();
        chk("after_skid_pc", ipc, 32'h10);

        // Redirect while the fetch is still waiting on memory.
        rdy = 1'b0; br = 1'b1; tgt = 32'h0000_0100;
        step();
        chk("kill_addr", addr, 32'h14);
        chk("kill_valid", 32'(vld), 32'd0);
        br = 1'b0;
        step();
        step();
        chk("kill_addr_held", addr, 32'h14);
        rdy = 1'b1;
        step();
        chk("redir_addr", addr, 32'h100);
        chk("redir_valid", 32'(vld), 32'd0);
        step();
        chk("redir_pc", ipc, 32'h100);

        // Redirect while stalled with the skid full, unaligned target.
        stall = 1'b1;
        step();
        chk("skid_full_req", 32'(req), 32'd0);
        br = 1'b1; tgt = 32'h0000_0203;
        step();
        chk("flush_valid", 32'(vld), 32'd0);
        chk("flush_addr", addr, 32'h200);
        br = 1'b0; stall = 1'b0;
        step();
        chk("flush_pc", ipc, 32'h200);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 99) < 30);
            rdy   = ($urandom_range(0, 99) < 60);
            br    = ($urandom_range(0, 99) < 8);
            tgt   = $urandom;
            step();
        end

        // Reset in the middle of a killed fetch.
        stall = 1'b0; br = 1'b0; rdy = 1'b0;
        step();
        br = 1'b1; tgt = 32'h0000_0444;
        step();
        br = 1'b0;
        step();
        chk("pre_rst_req", 32'(req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(req), 32'd0);
        chk("mid_rst_valid", 32'(vld), 32'd0);
        chk("mid_rst_addr", addr, RST0);
        m_reset(RST0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy = 1'b1;
        step();
        chk("restart_addr", addr, RST0);
        step();
        chk("restart_pc", ipc, RST0);
        for (int i = 0; i < 20; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
